pux_so: RTL and testbench

- Host-side stream originator for the pux_si slave interface: issues one opcode, then streams operand words to the A, B and M buffer streams, then collects one status word.
- Operand words are read from a single-port local operand RAM (one-cycle read latency). Each transfer is launched by a simple command port.
- Sits between the command/register layer and pux_si; every pux_si input stream is mastered here.

---
 rtl/pux_so.sv | 186 ++++++++++++++++++
 tb/tb_pux_so.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pux_so.sv
// Host-side stream originator: sends one opcode, streams A/B/M operand words
// fetched from a local RAM, then collects one status word from pux_si.
module pux_so #(
   parameter int OPCW  = 8,
   parameter int DATAW = 16,
   parameter int LENW  = 6
) (
   input  logic              axis_clk,
   input  logic              axis_rstn,
   input  logic              cmd_start,
   input  logic [OPCW-1:0]   cmd_opcode,
   input  logic [LENW-1:0]   cmd_len,
   output logic              cmd_busy,
   output logic              res_valid,
   output logic [DATAW-1:0]  res_status,
   output logic              mem_rd,
   output logic [LENW+1:0]   mem_addr,
   input  logic [DATAW-1:0]  mem_rdata,
   output logic [OPCW-1:0]   axis_opcode_data,
   output logic              axis_opcode_valid,
   input  logic              axis_opcode_ready,
   output logic [DATAW-1:0]  axis_abuff_data,
   output logic              axis_abuff_valid,
   input  logic              axis_abuff_ready,
   output logic [DATAW-1:0]  axis_bbuff_data,
   output logic              axis_bbuff_valid,
   input  logic              axis_bbuff_ready,
   output logic [DATAW-1:0]  axis_mbuff_data,
   output logic              axis_mbuff_valid,
   input  logic              axis_mbuff_ready,
   input  logic [DATAW-1:0]  axis_status_data,
   input  logic              axis_status_valid,
   output logic              axis_status_ready,
   input  logic              stream_reqest
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPC,
      S_WAIT_REQ,
      S_FETCH,
      S_SEND,
      S_STATUS
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_fph;
   logic [LENW-1:0]   r_idx;
   logic [LENW-1:0]   r_len;
   logic [OPCW-1:0]   r_opc;
   logic              r_req_pend;
   logic              r_avld;
   logic              r_bvld;
   logic              r_mvld;
   logic [DATAW-1:0]  r_adat;
   logic [DATAW-1:0]  r_bdat;
   logic [DATAW-1:0]  r_mdat;
   logic              r_busy;
   logic              r_res_vld;
   logic [DATAW-1:0]  r_res_dat;

   logic              w_req;
   logic              w_word_done;
   logic              w_stat_xfer;
   logic [LENW-1:0]   w_idx_inc;

   assign w_req       = r_req_pend | stream_reqest;
   assign w_idx_inc   = r_idx + 1'b1;
   assign w_stat_xfer = (r_state == S_STATUS) && axis_status_valid;
   // A word is finished once every still-pending stream transfers this cycle.
   assign w_word_done = (r_state == S_SEND)
                        && (!r_avld || axis_abuff_ready)
                        && (!r_bvld || axis_bbuff_ready)
                        && (!r_mvld || axis_mbuff_ready);

   always_comb begin
      w_state_nxt       = r_state;
      mem_rd            = 1'b0;
      mem_addr          = '0;
      axis_opcode_valid = 1'b0;
      axis_status_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_start) w_state_nxt = S_OPC;
         end
         S_OPC: begin
            axis_opcode_valid = 1'b1;
            if (axis_opcode_ready) w_state_nxt = (r_len == '0) ? S_STATUS : S_WAIT_REQ;
         end
         S_WAIT_REQ: begin
            if (w_req) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            // Phases 0..2 double as the RAM bank select for A, B, M.
            if (r_fph != 2'd3) begin
               mem_rd   = 1'b1;
               mem_addr = {r_fph, r_idx};
            end else begin
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (w_word_done) w_state_nxt = (w_idx_inc == r_len) ? S_STATUS : S_FETCH;
         end
         S_STATUS: begin
            axis_status_ready = 1'b1;
            if (axis_status_valid) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge axis_clk or posedge axis_rstn) begin
      if (axis_rstn) begin
         r_state    <= S_IDLE;
         r_fph      <= '0;
         r_idx      <= '0;
         r_len      <= '0;
         r_opc      <= '0;
         r_req_pend <= 1'b0;
         r_avld     <= 1'b0;
         r_bvld     <= 1'b0;
         r_mvld     <= 1'b0;
         r_adat     <= '0;
         r_bdat     <= '0;
         r_mdat     <= '0;
         r_busy     <= 1'b0;
         r_res_vld  <= 1'b0;
         r_res_dat  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_res_vld <= w_stat_xfer;
         r_fph     <= (r_state == S_FETCH) ? r_fph + 2'd1 : 2'd0;

         if (r_state == S_IDLE && cmd_start) begin
            r_opc  <= cmd_opcode;
            r_len  <= cmd_len;
            r_idx  <= '0;
            r_busy <= 1'b1;
         end

         // A request pulse coinciding with the opcode transfer must survive into WAIT_REQ.
         case (r_state)
            S_OPC:      r_req_pend <= (axis_opcode_ready && r_len == '0) ? 1'b0 : w_req;
            S_WAIT_REQ: r_req_pend <= w_req ? 1'b0 : r_req_pend;
            default:    r_req_pend <= 1'b0;
         endcase

         if (r_state == S_FETCH) begin
            if (r_fph == 2'd1) r_adat <= mem_rdata;
            if (r_fph == 2'd2) r_bdat <= mem_rdata;
            if (r_fph == 2'd3) begin
               r_mdat <= mem_rdata;
               r_avld <= 1'b1;
               r_bvld <= 1'b1;
               r_mvld <= 1'b1;
            end
         end

         if (r_state == S_SEND) begin
            if (r_avld && axis_abuff_ready) r_avld <= 1'b0;
            if (r_bvld && axis_bbuff_ready) r_bvld <= 1'b0;
            if (r_mvld && axis_mbuff_ready) r_mvld <= 1'b0;
            if (w_word_done) r_idx <= w_idx_inc;
         end

         if (w_stat_xfer) begin
            r_res_dat <= axis_status_data;
            r_busy    <= 1'b0;
         end
      end
   end

   assign cmd_busy         = r_busy;
   assign res_valid        = r_res_vld;
   assign res_status       = r_res_dat;
   assign axis_opcode_data = r_opc;
   assign axis_abuff_data  = r_adat;
   assign axis_abuff_valid = r_avld;
   assign axis_bbuff_data  = r_bdat;
   assign axis_bbuff_valid = r_bvld;
   assign axis_mbuff_data  = r_mdat;
   assign axis_mbuff_valid = r_mvld;

endmodule

// File: tb/tb_pux_so.sv
// Bench for pux_so: RAM model, stream monitors and a reference built from the
// command (opcode once, RAM words in order per stream, one status capture).
module tb_pux_so;
   localparam int OPCW  = 8;
   localparam int DATAW = 16;
   localparam int LENW  = 6;

   logic             axis_clk = 1'b0;
   logic             axis_rstn;
   logic             cmd_start;
   logic [OPCW-1:0]  cmd_opcode;
   logic [LENW-1:0]  cmd_len;
   logic             cmd_busy, res_valid;
   logic [DATAW-1:0] res_status;
   logic             mem_rd;
   logic [LENW+1:0]  mem_addr;
   logic [DATAW-1:0] mem_rdata;
   logic [OPCW-1:0]  axis_opcode_data;
   logic             axis_opcode_valid, axis_opcode_ready;
   logic [DATAW-1:0] axis_abuff_data, axis_bbuff_data, axis_mbuff_data;
   logic             axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid;
   logic             axis_abuff_ready, axis_bbuff_ready, axis_mbuff_ready;
   logic [DATAW-1:0] axis_status_data;
   logic             axis_status_valid, axis_status_ready;
   logic             stream_reqest;

   always #5 axis_clk = ~axis_clk;

   pux_so #(.OPCW(OPCW), .DATAW(DATAW), .LENW(LENW)) dut (
      .axis_clk(axis_clk), .axis_rstn(axis_rstn),
      .cmd_start(cmd_start), .cmd_opcode(cmd_opcode), .cmd_len(cmd_len),
      .cmd_busy(cmd_busy), .res_valid(res_valid), .res_status(res_status),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .axis_opcode_data(axis_opcode_data), .axis_opcode_valid(axis_opcode_valid),
      .axis_opcode_ready(axis_opcode_ready),
      .axis_abuff_data(axis_abuff_data), .axis_abuff_valid(axis_abuff_valid),
      .axis_abuff_ready(axis_abuff_ready),
      .axis_bbuff_data(axis_bbuff_data), .axis_bbuff_valid(axis_bbuff_valid),
      .axis_bbuff_ready(axis_bbuff_ready),
      .axis_mbuff_data(axis_mbuff_data), .axis_mbuff_valid(axis_mbuff_valid),
      .axis_mbuff_ready(axis_mbuff_ready),
      .axis_status_data(axis_status_data), .axis_status_valid(axis_status_valid),
      .axis_status_ready(axis_status_ready), .stream_reqest(stream_reqest)
   );

   // Operand RAM: one-cycle read latency, bank = addr[7:6].
   logic [DATAW-1:0] ram [0:255];
   always @(posedge axis_clk) if (mem_rd) mem_rdata <= ram[mem_addr];

   logic [OPCW-1:0]  opc_got [$];
   logic [DATAW-1:0] a_got [$], b_got [$], m_got [$];
   int n_rd = 0, n_res = 0, v_fetch = 0, v_stab = 0;
   logic a_sp = 0, b_sp = 0, m_sp = 0, o_sp = 0;
   logic [DATAW-1:0] a_dp, b_dp, m_dp;
   logic [OPCW-1:0]  o_dp;

   // Transfer monitor, sampled mid-cycle; also flags data/valid instability
   // under stall and any RAM read while a word is still being sent.
   always @(negedge axis_clk) begin
      if (axis_rstn) begin
         a_sp <= 1'b0; b_sp <= 1'b0; m_sp <= 1'b0; o_sp <= 1'b0;
      end else begin
         if (axis_opcode_valid && axis_opcode_ready) opc_got.push_back(axis_opcode_data);
         if (axis_abuff_valid && axis_abuff_ready) a_got.push_back(axis_abuff_data);
         if (axis_bbuff_valid && axis_bbuff_ready) b_got.push_back(axis_bbuff_data);
         if (axis_mbuff_valid && axis_mbuff_ready) m_got.push_back(axis_mbuff_data);
         if (mem_rd) n_rd <= n_rd + 1;
         if (res_valid) n_res <= n_res + 1;
         if (mem_rd && (axis_abuff_valid || axis_bbuff_valid || axis_mbuff_valid))
            v_fetch <= v_fetch + 1;
         v_stab <= v_stab
            + ((a_sp && (!axis_abuff_valid || axis_abuff_data !== a_dp)) ? 1 : 0)
            + ((b_sp && (!axis_bbuff_valid || axis_bbuff_data !== b_dp)) ? 1 : 0)
            + ((m_sp && (!axis_mbuff_valid || axis_mbuff_data !== m_dp)) ? 1 : 0)
            + ((o_sp && (!axis_opcode_valid || axis_opcode_data !== o_dp)) ? 1 : 0);
         a_sp <= axis_abuff_valid && !axis_abuff_ready;  a_dp <= axis_abuff_data;
         b_sp <= axis_bbuff_valid && !axis_bbuff_ready;  b_dp <= axis_bbuff_data;
         m_sp <= axis_mbuff_valid && !axis_mbuff_ready;  m_dp <= axis_mbuff_data;
         o_sp <= axis_opcode_valid && !axis_opcode_ready; o_dp <= axis_opcode_data;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATAW-1:0] ram_word(input int sel, input int i);
      return ram[sel * 64 + i];
   endfunction

   // Runs one command from IDLE; entered and left at posedge+1 so a following
   // call lands its cmd_start in the cycle right after res_valid.
   // req_dly=0: request in the opcode-transfer cycle. bp: 0 none, 1 random, 2 directed.
   task automatic run_cmd(input logic [7:0] opc, input int len, input int req_dly,
                          input int bp, input bit poke, input logic [15:0] stat);
      int b_o = opc_got.size(), b_a = a_got.size(), b_b = b_got.size(), b_m = m_got.size();
      int b_rd = n_rd, b_res = n_res, b_fv = v_fetch, b_sv = v_stab;
      int opx = -1, srdy = -1, bcyc = 0;
      bit done = 0, req_done = 0, drop_ok = 0, prev_adrop = 0;
      axis_status_data  = stat;
      axis_status_valid = 1'b1;
      cmd_opcode = opc;
      cmd_len    = LENW'(len);
      cmd_start  = 1'b1;
      @(posedge axis_clk); #1;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         cmd_start  = poke && cyc == 3;
         cmd_opcode = (poke && cyc == 3) ? ~opc : opc;
         case (bp)
            1: begin
               axis_opcode_ready = ($urandom_range(0, 3) != 0);
               axis_abuff_ready  = ($urandom_range(0, 2) != 0);
               axis_bbuff_ready  = ($urandom_range(0, 2) != 0);
               axis_mbuff_ready  = ($urandom_range(0, 2) != 0);
            end
            2: begin
               axis_opcode_ready = 1'b1;
               axis_abuff_ready  = 1'b1;
               axis_bbuff_ready  = (bcyc >= 5);
               axis_mbuff_ready  = cyc[0];
            end
            default: begin
               axis_opcode_ready = 1'b1;
               axis_abuff_ready  = 1'b1;
               axis_bbuff_ready  = 1'b1;
               axis_mbuff_ready  = 1'b1;
            end
         endcase
         stream_reqest = 1'b0;
         if (!req_done) begin
            if (req_dly == 0 && axis_opcode_valid && axis_opcode_ready) begin
               stream_reqest = 1'b1; req_done = 1;
            end else if (req_dly > 0 && opx >= 0 && cyc == opx + req_dly) begin
               stream_reqest = 1'b1; req_done = 1;
            end
         end
         @(negedge axis_clk);
         if (cyc == 0) chk("busy_on", cmd_busy, 1);
         if (axis_opcode_valid && axis_opcode_ready) opx = cyc;
         if (srdy < 0 && axis_status_ready) srdy = cyc;
         if (axis_abuff_valid || axis_bbuff_valid || axis_mbuff_valid) bcyc++;
         if (prev_adrop && !axis_abuff_valid && axis_bbuff_valid) drop_ok = 1;
         prev_adrop = axis_abuff_valid && axis_abuff_ready && axis_bbuff_valid && !axis_bbuff_ready;
         if (res_valid) begin
            done = 1;
            chk("busy_off", cmd_busy, 0);
            chk("res_status", res_status, stat);
         end
         @(posedge axis_clk); #1;
      end
      stream_reqest = 1'b0;
      cmd_start     = 1'b0;
      chk("cmd_done", done, 1);
      chk("res_pulse", res_valid, 0);
      chk("res_hold", res_status, stat);
      chk("res_count", n_res - b_res, 1);
      chk("opc_count", opc_got.size() - b_o, 1);
      if (opc_got.size() > b_o) chk("opc_data", opc_got[b_o], opc);
      chk("a_count", a_got.size() - b_a, len);
      chk("b_count", b_got.size() - b_b, len);
      chk("m_count", m_got.size() - b_m, len);
      for (int i = 0; i < len; i++) begin
         if (b_a + i < a_got.size()) chk("a_word", a_got[b_a + i], ram_word(0, i));
         if (b_b + i < b_got.size()) chk("b_word", b_got[b_b + i], ram_word(1, i));
         if (b_m + i < m_got.size()) chk("m_word", m_got[b_m + i], ram_word(2, i));
      end
      chk("rd_count", n_rd - b_rd, 3 * len);
      chk("fetch_overlap", v_fetch - b_fv, 0);
      chk("stable", v_stab - b_sv, 0);
      if (bp == 2) chk("a_drop", drop_ok, 1);
      if (len == 0) chk("stat_rdy_cyc", srdy, opx + 1);
   endtask

   initial begin
      bit seen;
      axis_rstn = 1'b1;
      cmd_start = 1'b0; cmd_opcode = '0; cmd_len = '0;
      axis_opcode_ready = 1'b0; axis_abuff_ready = 1'b0;
      axis_bbuff_ready = 1'b0; axis_mbuff_ready = 1'b0;
      axis_status_data = '0; axis_status_valid = 1'b0; stream_reqest = 1'b0;
      for (int i = 0; i < 256; i++) ram[i] = DATAW'($urandom);

      repeat (2) @(posedge axis_clk);
      @(negedge axis_clk);
      chk("rst_busy", cmd_busy, 0);
      chk("rst_resv", res_valid, 0);
      chk("rst_ress", res_status, 0);
      chk("rst_memrd", mem_rd, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_opv", axis_opcode_valid, 0);
      chk("rst_opd", axis_opcode_data, 0);
      chk("rst_vld", {axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid}, 0);
      chk("rst_dat", axis_abuff_data | axis_bbuff_data | axis_mbuff_data, 0);
      chk("rst_srdy", axis_status_ready, 0);
      @(posedge axis_clk); #1 axis_rstn = 1'b0;

      ram[0] = 16'h1111;   ram[1] = 16'h2222;
      ram[64] = 16'h3333;  ram[65] = 16'h4444;
      ram[128] = 16'h5555; ram[129] = 16'h6666;
      run_cmd(8'h17, 2, 3, 0, 0, 16'hBEEF);
      run_cmd(8'h17, 2, 3, 2, 0, 16'h1234);
      run_cmd(8'h42, 3, 0, 0, 0, 16'hA5A5);
      run_cmd(8'h05, 0, 1, 0, 0, 16'h0F0F);
      run_cmd(8'h21, 3, 2, 0, 1, 16'hC001);
      run_cmd(8'h22, 1, 1, 0, 0, 16'hD00D);
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 256; i++) ram[i] = DATAW'($urandom);
         run_cmd(8'($urandom), $urandom_range(0, 8), $urandom_range(0, 4), 1,
                 1'($urandom_range(0, 1)), 16'($urandom));
      end
      run_cmd(8'h3F, 63, 2, 0, 0, 16'h6363);

      // Reset while stalled in SEND.
      axis_abuff_ready = 1'b0; axis_bbuff_ready = 1'b0; axis_mbuff_ready = 1'b0;
      axis_opcode_ready = 1'b1; axis_status_valid = 1'b0;
      cmd_opcode = 8'h33; cmd_len = 6'd3; cmd_start = 1'b1;
      @(posedge axis_clk); #1 cmd_start = 1'b0;
      seen = 0;
      for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
         stream_reqest = (cyc == 2);
         @(negedge axis_clk);
         if (axis_abuff_valid) seen = 1;
         @(posedge axis_clk); #1;
      end
      stream_reqest = 1'b0;
      chk("rst_reach_send", seen, 1);
      axis_rstn = 1'b1;
      #1;
      chk("mid_rst_vld", {axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid}, 0);
      chk("mid_rst_memrd", mem_rd, 0);
      chk("mid_rst_busy", cmd_busy, 0);
      @(posedge axis_clk); #1 axis_rstn = 1'b0;
      repeat (2) begin
         @(negedge axis_clk);
         chk("post_rst_idle", {axis_opcode_valid, axis_status_ready, cmd_busy, mem_rd,
                               axis_abuff_valid}, 0);
      end
      @(posedge axis_clk); #1;
      run_cmd(8'h99, 2, 1, 0, 0, 16'h5A5A);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
